// File: rtl/display_uart_tx.sv
// display_uart_tx
// Captures bytes from the CPU display path on each rising edge of in_valid,
// buffers them in a small FIFO and sends them as UART 8N1 on tx.
//
// Ports
//   clk       board clock, all logic on rising edge
//   rst       synchronous reset, active-low
//   in        byte from the display path
//   in_valid  display trigger (level); one push per rising edge
//   tx        UART serial line, idle high (registered)
//   busy      high while a frame is on the line (registered)
//   count     number of bytes currently buffered
//   full      count equals FIFO depth
//   overflow  sticky; set when a byte is dropped on a full FIFO
//
// state | meaning
// IDLE  | line idle, pop as soon as a byte is buffered
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1), then pop the next byte or go idle
module display_uart_tx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [15:0]        BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic                 in_valid_d;
  logic                 push_req, push_ok, pop, bit_end, tx_n;

  assign full     = (count == CNT_FULL);
  assign push_req = in_valid & ~in_valid_d;
  // A pop in the same cycle does not make room for a push into a full FIFO.
  assign push_ok  = push_req & ~full;
  assign bit_end  = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          // Back-to-back frames: go straight to START without an idle cycle.
          if (count != '0) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      in_valid_d <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      tx         <= tx_n;
      busy       <= (state != IDLE);

      if (push_ok)  wr_ptr   <= wr_ptr + PTR_ONE;
      if (push_req && full) overflow <= 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end else if (state == DATA && bit_end) begin
        shift <= {1'b0, shift[7:1]};
      end

      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 16'd1;

      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_display_uart_tx.sv
module tb_display_uart_tx;
  localparam int CPB   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          in_valid = 1'b0;
  logic          tx, busy, full, overflow;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  display_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .tx(tx), .busy(busy), .count(count), .full(full), .overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a byte queue plus the position inside the current frame.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_fpos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_prev = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_tx = 1'b1;
  bit         m_busy = 1'b0;

  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  int         busy_cycles = 0;
  int         busy_rises = 0;
  logic       busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic model_edge();
    int pre;
    bit end_now;
    if (!rst) begin
      q.delete();
      m_active = 1'b0; m_prev = 1'b0; m_ovf = 1'b0;
      m_tx = 1'b1; m_busy = 1'b0; m_fpos = 0;
      return;
    end
    pre = q.size();
    end_now = 1'b0;
    if (m_active) begin
      m_tx = frame_bit(m_byte, m_fpos / CPB);
      m_busy = 1'b1;
      end_now = (m_fpos == 10*CPB - 1);
    end else begin
      m_tx = 1'b1;
      m_busy = 1'b0;
    end
    if (!m_active || end_now) begin
      if (pre > 0) begin
        m_byte = q.pop_front();
        m_active = 1'b1;
        m_fpos = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_fpos++;
    end
    if (in_valid && !m_prev) begin
      if (pre < DEPTH) begin
        q.push_back(din);
        acc_q.push_back(din);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_prev = in_valid;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", tx, m_tx);
    check("busy", busy, m_busy);
    check("count", count, q.size());
    check("full", full, (q.size() == DEPTH));
    check("overflow", overflow, m_ovf);
    if (busy) busy_cycles++;
    if (busy && !busy_prev) busy_rises++;
    busy_prev = busy;
    if (!rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      for (int k = 1; k <= 8; k++)
        if (rx_cnt == CPB/2 + CPB*k) rx_sh[k-1] = tx;
      if (rx_cnt == CPB/2 + CPB*9) begin
        check("rx_stop_bit", tx, 1'b1);
        rx_q.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  endtask

  task automatic pulse(input logic [7:0] b, input int hi, input int lo);
    din = b;
    in_valid = 1'b1;
    repeat (hi) step();
    in_valid = 1'b0;
    repeat (lo) step();
  endtask

  task automatic drain(input string tag, input int max);
    bit done;
    for (int i = 0; i < max && (m_active || q.size() > 0 || rx_on); i++) step();
    done = !(m_active || q.size() > 0 || rx_on);
    check(tag, done, 1'b1);
    repeat (3) step();
  endtask

  task automatic compare_rx(input string tag);
    check(tag, rx_q.size(), acc_q.size());
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
      check(tag, rx_q[i], acc_q[i]);
  endtask

  task automatic clear_stats();
    rx_q.delete();
    acc_q.delete();
    busy_cycles = 0;
    busy_rises = 0;
  endtask

  initial begin
    logic [7:0] exp4[$];

    // 1: reset then idle
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    clear_stats();
    repeat (50) step();
    check("t1_busy_cycles", busy_cycles, 0);

    // 2: single byte, in_valid held 16 cycles
    clear_stats();
    din = 8'hA5;
    in_valid = 1'b1;
    step();
    check("t2_count_after_push", count, 1);
    step();
    check("t2_count_after_pop", count, 0);
    repeat (14) step();
    in_valid = 1'b0;
    drain("t2_drain", 200);
    check("t2_busy_cycles", busy_cycles, 40);
    check("t2_frames", busy_rises, 1);
    check("t2_rx_size", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t2_rx_byte", rx_q[0], 8'hA5);

    // 3: back-to-back frames
    clear_stats();
    pulse(8'h01, 1, 1);
    pulse(8'h02, 1, 1);
    pulse(8'h03, 1, 1);
    drain("t3_drain", 400);
    check("t3_busy_cycles", busy_cycles, 120);
    check("t3_busy_rises", busy_rises, 1);
    compare_rx("t3_rx");

    // 4: overflow
    clear_stats();
    for (int i = 0; i < 10; i++) pulse(8'(8'h10 + i), 1, 1);
    check("t4_full", full, 1'b1);
    check("t4_overflow", overflow, 1'b1);
    check("t4_count", count, 8);
    drain("t4_drain", 600);
    for (int i = 0; i < 9; i++) exp4.push_back(8'(8'h10 + i));
    check("t4_rx_size", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) check("t4_rx_byte", rx_q[i], exp4[i]);
    check("t4_overflow_sticky", overflow, 1'b1);
    check("t4_busy_cycles", busy_cycles, 360);

    // 5: wrap-around, 20 random bytes in groups of 5
    clear_stats();
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 5; j++) pulse(8'($urandom), 1, 1);
      drain("t5_drain", 400);
    end
    compare_rx("t5_rx");
    check("t5_rx_count", rx_q.size(), 20);
    check("t5_count_empty", count, 0);

    // random traffic, including drops on a full FIFO
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      din = 8'($urandom);
      in_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    drain("rand_drain", 1000);
    compare_rx("rand_rx");

    // 6: reset during DATA bit 3
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_stats();
    pulse(8'hFF, 1, 1);
    for (int j = 0; j < 3; j++) pulse(8'($urandom), 1, 1);
    for (int i = 0; i < 200 && !(m_active && (m_fpos / CPB) == 4); i++) step();
    check("t6_reach_bit3", (m_active && (m_fpos / CPB) == 4), 1'b1);
    rst = 1'b0;
    step();
    check("t6_tx_at_reset", tx, 1'b1);
    check("t6_count_at_reset", count, 0);
    check("t6_busy_at_reset", busy, 1'b0);
    step();
    rst = 1'b1;
    clear_stats();
    repeat (100) step();
    check("t6_no_frames", rx_q.size(), 0);
    check("t6_no_busy", busy_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
Downstream consumer of the CPU's 8-bit display output (OUT byte plus OUT_EN trigger). It captures each byte on the rising edge of the trigger, buffers it in a small FIFO, and serialises it as UART 8N1 on a single tx pin. It runs on the 16 MHz board clock, the same clock that feeds the clock divider. The bytes written by the CPU therefore appear on a host serial terminal.

Parameters:
CLKS_PER_BIT, 139, clk cycles per UART bit (16 MHz / 115200 ≈ 139); legal range 2..65535
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW entries (8)

Ports:
clk  input  1  board clock, all logic on rising edge
rst  input  1  synchronous reset, active-low; when low at a clk edge, every register takes its reset value
in  input  8  byte from display path (OUT)
in_valid  input  1  display trigger (OUT_EN); level signal, may stay high for many clk cycles
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is on the line (START, DATA or STOP state)
count  output  FIFO_AW+1  number of bytes currently buffered
full  output  1  count == 2^FIFO_AW
overflow  output  1  sticky; set when a byte is dropped because the FIFO is full

Behaviour:
- Reset (rst low at edge) produces: tx=1, busy=0, count=0, full=0, overflow=0, state=IDLE. FIFO pointers, bit counter, baud counter, shift register and in_valid_d are all cleared.
- in_valid is assumed synchronous to clk; no synchroniser is included.
- Edge detect: in_valid_d is registered every cycle. A push request occurs at an edge where in_valid=1 and in_valid_d=0. A held-high in_valid produces exactly one push.
- Push: accepted if count < 2^FIFO_AW before that edge. `in` is written at wr_ptr and wr_ptr increments.
  - If the FIFO is full, the byte is dropped, FIFO contents are unchanged, and overflow is set to 1.
  - A pop in the same cycle does not rescue a push into a full FIFO.
- Pointers are FIFO_AW bits and wrap naturally. count is updated as +1 for push only, -1 for pop only, and unchanged for push and pop together.
- FSM states:
  - IDLE: tx=1. If count != 0, pop: the shift register loads mem[rd_ptr], rd_ptr increments, the baud counter is cleared, and the next state is START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if count != 0, pop and go directly to START (back-to-back frames with no extra idle cycle); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; the bit ends on the cycle the counter equals CLKS_PER_BIT-1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx and busy are registered outputs (no combinational path from in or in_valid to tx).
- Latency: a push sampled at edge k into an empty FIFO while in IDLE leads to the pop at edge k+1, tx=0 from edge k+2, and busy=1 from edge k+2.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- Reset mid-frame: tx returns to 1 on the reset edge. The partial frame is abandoned and buffered bytes are discarded.
- overflow clears only on reset.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=3):
1. Reset then idle: hold rst low for 3 cycles, release. Required: tx=1, busy=0, count=0, overflow=0 for 50 cycles.
2. Single byte: in=8'hA5, in_valid pulsed high for 16 cycles. Required:
   - count goes 1 then 0 on the next edge.
   - tx sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
   - busy high for exactly 40 cycles; exactly one frame sent.
3. Back-to-back: push 8'h01, 8'h02, 8'h03 on three separate rising edges, 2 cycles apart. Required: three contiguous frames, 120 busy cycles with no idle gap, decoded bytes 01, 02, 03 in order.
4. Overflow: push 10 bytes 8'h10..8'h19 within 30 cycles (before the first frame ends). Required:
   - 8'h10 is popped immediately; FIFO holds 8'h11..8'h18; full=1.
   - 8'h19 is dropped; overflow=1 and stays 1 through all 9 frames.
   - Decoded output is 10..18.
5. Wrap-around: send 20 bytes in groups of 5, each group spaced so the FIFO drains between groups. Required: all 20 bytes received in order, pointers wrap without corruption, count returns to 0.
6. Reset mid-frame: start a frame of 8'hFF plus 3 queued bytes, assert rst during DATA bit 3. Required: tx=1, count=0, busy=0 at the reset edge; no further frames after rst releases.
